// File: rtl/ift_mon_pkg.sv
// ift_mon_pkg: shared types and helpers for the taint monitor.
package ift_mon_pkg;
  typedef enum logic [1:0] {EV_SET = 2'd0, EV_CLR = 2'd1, EV_CHG = 2'd2, EV_DAT = 2'd3} ev_type_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BASE = 2'd1, RUN = 2'd2} mon_state_e;
  function automatic int rec_w(int dw, int tw, int tsw);
    return 2 + tsw + tw + dw;
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] v, int w);
    return (v == (32'(1) << w) - 32'(1)) ? v : v + 32'(1);
  endfunction
endpackage

// File: rtl/ift_mon_fifo.sv
// ift_mon_fifo: synchronous FIFO, pointers carry an extra wrap bit to tell full from empty.
module ift_mon_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic do_rd, do_wr;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_wr);
      rp <= rp + (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ift_taint_monitor.sv
// ift_taint_monitor: classifies taint events on an IFT cell output and logs them with timestamps.
// Optional label filtering is enabled by defining IFT_MON_FILTER_EN.
module ift_taint_monitor import ift_mon_pkg::*; #(
  parameter int DW = 2,
  parameter int TW = 32,
  parameter int TSW = 16,
  parameter int DEPTH = 8,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           clear,
  input  logic [DW-1:0]  q_in,
  input  logic [TW-1:0]  q_t_in,
`ifdef IFT_MON_FILTER_EN
  input  logic [TW-1:0]  lbl_mask,
`endif
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [1:0]     ev_type,
  output logic [TSW-1:0] ev_ts,
  output logic [TW-1:0]  ev_taint,
  output logic [DW-1:0]  ev_data,
  output logic [CW-1:0]  cnt_set,
  output logic [CW-1:0]  cnt_clr,
  output logic [CW-1:0]  cnt_chg,
  output logic [CW-1:0]  cnt_dat,
  output logic [CW-1:0]  cnt_drop,
  output logic           overflow,
  output logic           busy
);
  localparam int RW = rec_w(DW, TW, TSW);
  mon_state_e state, state_nx;
  logic [TW-1:0] t_in, cur_t, prev_t;
  logic [DW-1:0] cur_d, prev_d;
  logic [TSW-1:0] ts;
  logic det, push_v, accept, full, empty;
  ev_type_e det_type, push_type;
  logic [RW-1:0] push_rec, head;
`ifdef IFT_MON_FILTER_EN
  assign t_in = q_t_in & lbl_mask;
`else
  assign t_in = q_t_in;
`endif
  always_comb begin
    state_nx = state;
    if (stop) state_nx = IDLE;
    else if (state == IDLE) state_nx = start ? BASE : IDLE;
    else if (state == BASE) state_nx = RUN;
  end
  assign busy = state != IDLE;
  assign det_type = ~|prev_t ? EV_SET : ~|cur_t ? EV_CLR : (cur_t != prev_t) ? EV_CHG : EV_DAT;
  assign det = (state == RUN) && (|prev_t || |cur_t) && (cur_t != prev_t || cur_d != prev_d);
  assign push_type = ev_type_e'(push_rec[RW-1 -: 2]);
  // A full FIFO still takes the record when the consumer pops in the same cycle.
  assign accept = push_v && !clear && (!full || (ev_ready && !empty));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_t <= '0;
      cur_d <= '0;
      prev_t <= '0;
      prev_d <= '0;
      ts <= '0;
      push_v <= 1'b0;
      push_rec <= '0;
      cnt_set <= '0;
      cnt_clr <= '0;
      cnt_chg <= '0;
      cnt_dat <= '0;
      cnt_drop <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      cur_t <= t_in;
      cur_d <= q_in;
      prev_t <= cur_t;
      prev_d <= cur_d;
      push_rec <= {det_type, ts, cur_t, cur_d};
      if (clear) begin
        ts <= '0;
        push_v <= 1'b0;
        cnt_set <= '0;
        cnt_clr <= '0;
        cnt_chg <= '0;
        cnt_dat <= '0;
        cnt_drop <= '0;
        overflow <= 1'b0;
      end else begin
        if (state != IDLE) ts <= ts + 1'b1;
        push_v <= det;
        if (push_v) begin
          cnt_set <= (push_type == EV_SET) ? CW'(sat_inc(32'(cnt_set), CW)) : cnt_set;
          cnt_clr <= (push_type == EV_CLR) ? CW'(sat_inc(32'(cnt_clr), CW)) : cnt_clr;
          cnt_chg <= (push_type == EV_CHG) ? CW'(sat_inc(32'(cnt_chg), CW)) : cnt_chg;
          cnt_dat <= (push_type == EV_DAT) ? CW'(sat_inc(32'(cnt_dat), CW)) : cnt_dat;
          if (!accept) begin
            cnt_drop <= CW'(sat_inc(32'(cnt_drop), CW));
            overflow <= 1'b1;
          end
        end
      end
    end
  end
  ift_mon_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .wr(accept),
    .rd(ev_ready),
    .wdata(push_rec),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign ev_valid = !empty;
  assign {ev_type, ev_ts, ev_taint, ev_data} = head;
endmodule

// File: tb/tb_ift_taint_monitor.sv
// tb_ift_taint_monitor: directed self-checking bench for ift_taint_monitor.
module tb_ift_taint_monitor;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, ev_ready = 1'b0;
  logic [1:0] q_in = '0;
  logic [31:0] q_t_in = '0;
`ifdef IFT_MON_FILTER_EN
  logic [31:0] lbl_mask = '1;
`endif
  logic ev_valid, overflow, busy;
  logic [1:0] ev_type, ev_data;
  logic [15:0] ev_ts;
  logic [31:0] ev_taint;
  logic [7:0] cnt_set, cnt_clr, cnt_chg, cnt_dat, cnt_drop;
  int checks = 0, errors = 0;
  int exp_t [8] = '{2, 3, 4, 5, 6, 7, 8, 11};
  always #5 clk = ~clk;
  ift_taint_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .q_in(q_in), .q_t_in(q_t_in),
`ifdef IFT_MON_FILTER_EN
    .lbl_mask(lbl_mask),
`endif
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_ts(ev_ts),
    .ev_taint(ev_taint), .ev_data(ev_data), .cnt_set(cnt_set), .cnt_clr(cnt_clr),
    .cnt_chg(cnt_chg), .cnt_dat(cnt_dat), .cnt_drop(cnt_drop), .overflow(overflow), .busy(busy)
  );
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    check("rst_valid", ev_valid, 0);
    check("rst_ts", ev_ts, 0);
    check("rst_taint", ev_taint, 0);
    check("rst_cnt", {cnt_set, cnt_clr, cnt_chg, cnt_dat, cnt_drop}, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    // test 1: single SET event, detected with ts=4
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy", busy, 1);
    tick(3);
    q_t_in = 32'h1;
    tick(2);
    check("t1_latency", ev_valid, 0);
    tick();
    check("t1_valid", ev_valid, 1);
    check("t1_type", ev_type, 0);
    check("t1_taint", ev_taint, 32'h1);
    check("t1_ts", ev_ts, 4);
    check("t1_data", ev_data, 0);
    check("t1_cnt_set", cnt_set, 1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t1_pop", ev_valid, 0);
    // test 2: CHG then CLR, in order with their timestamps
    q_t_in = 32'h3;
    tick(3);
    q_t_in = 32'h0;
    tick(3);
    check("t2_type0", ev_type, 2);
    check("t2_ts0", ev_ts, 8);
    check("t2_taint0", ev_taint, 32'h3);
    ev_ready = 1'b1;
    tick();
    check("t2_type1", ev_type, 1);
    check("t2_ts1", ev_ts, 11);
    check("t2_taint1", ev_taint, 32'h0);
    tick();
    ev_ready = 1'b0;
    check("t2_empty", ev_valid, 0);
    check("t2_cnt", {cnt_chg, cnt_clr}, {8'd1, 8'd1});
    // test 3: data change under held taint
    q_t_in = 32'h4;
    ev_ready = 1'b1;
    tick(4);
    ev_ready = 1'b0;
    q_in = 2'b10;
    tick(3);
    check("t3_valid", ev_valid, 1);
    check("t3_type", ev_type, 3);
    check("t3_data", ev_data, 2'b10);
    check("t3_ts", ev_ts, 20);
    check("t3_taint", ev_taint, 32'h4);
    ev_ready = 1'b1;
    tick();
    q_t_in = 32'h0;
    tick(4);
    ev_ready = 1'b0;
    q_in = 2'b00;
    tick(4);
    check("t3_untainted", ev_valid, 0);
    check("t3_cnt_dat", cnt_dat, 1);
    check("t3_cnts", {cnt_set, cnt_clr}, {8'd2, 8'd2});
    // test 4: 10 events into a depth-8 FIFO with no consumer
    for (int i = 1; i <= 10; i++) begin
      q_t_in = 32'(i);
      tick();
    end
    tick(3);
    check("t4_drop", cnt_drop, 2);
    check("t4_ovf", overflow, 1);
    check("t4_valid", ev_valid, 1);
    check("t4_head", ev_taint, 32'h1);
    check("t4_cnts", {cnt_set, cnt_chg}, {8'd3, 8'd10});
    // test 5: event while full with a coincident pop is accepted
    q_t_in = 32'd11;
    tick(2);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t5_drop", cnt_drop, 2);
    check("t5_chg", cnt_chg, 11);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_drain%0d", i), ev_taint, 64'(exp_t[i]));
      tick();
    end
    ev_ready = 1'b0;
    check("t5_empty", ev_valid, 0);
    // clear coincident with a detected CLR event discards it
    q_t_in = 32'h0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(3);
    check("clr_valid", ev_valid, 0);
    check("clr_cnts", {cnt_set, cnt_clr, cnt_chg, cnt_dat, cnt_drop}, 0);
    check("clr_ovf", overflow, 0);
    check("clr_busy", busy, 1);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    check("stop_busy", busy, 0);
`ifdef IFT_MON_FILTER_EN
    // test 6: masked labels are invisible
    lbl_mask = 32'hFFFF_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    q_t_in = 32'h0000_00FF;
    tick(4);
    check("t6_masked", ev_valid, 0);
    q_t_in = 32'h0001_0000;
    tick(3);
    check("t6_valid", ev_valid, 1);
    check("t6_type", ev_type, 0);
    check("t6_taint", ev_taint, 32'h0001_0000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
